// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank game types and screen bounds
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FLYING   = 2'b01,
        ST_COOLDOWN = 2'b10
    } shell_state_t;

    localparam logic [9:0] X_MIN = 10'd1;
    localparam logic [9:0] X_MAX = 10'd639;
    localparam logic [9:0] Y_MIN = 10'd1;
    localparam logic [9:0] Y_MAX = 10'd479;

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - one-frame pulse when a given keycode first appears
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'd40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    output logic       key_edge
);

    logic [7:0] prev_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_key <= 8'd0;
        end else begin
            prev_key <= keycode;
        end
    end

    assign key_edge = (keycode == KEY) && (prev_key != KEY);

endmodule

// File: rtl/shell_ctrl.sv
// rtl/shell_ctrl.sv - single-shell projectile controller for one tank
module shell_ctrl
    import tank_pkg::*;
#(
    parameter logic [7:0] FIRE_KEY        = 8'd40,
    parameter logic [9:0] SHELL_SPEED     = 10'd4,
    parameter logic [9:0] SHELL_SIZE      = 10'd2,
    parameter logic [9:0] TANK_SIZE       = 10'd4,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] TankX,
    input  logic [9:0] TankY,
    input  logic [1:0] direction,
    input  logic       hit,
    output logic [9:0] ShellX,
    output logic [9:0] ShellY,
    output logic [9:0] ShellS,
    output logic       shell_active,
    output logic       fire_pulse
);

    // Bound checks run at 11 bits so sums of 10-bit values never wrap.
    localparam logic [10:0] OFF_W  = {1'b0, TANK_SIZE} + {1'b0, SHELL_SIZE};
    localparam logic [9:0]  OFFSET = OFF_W[9:0];
    localparam logic [10:0] SPD_W  = {1'b0, SHELL_SPEED};
    localparam logic [10:0] XMIN_W = {1'b0, X_MIN};
    localparam logic [10:0] XMAX_W = {1'b0, X_MAX};
    localparam logic [10:0] YMIN_W = {1'b0, Y_MIN};
    localparam logic [10:0] YMAX_W = {1'b0, Y_MAX};

    shell_state_t state, state_next;
    dir_t         shell_dir, dir_next, tank_dir;
    logic [9:0]   x_next, y_next, spawn_x, spawn_y;
    logic [7:0]   cnt, cnt_next;
    logic         pulse_next, fire_edge, spawn_ok, x_ok, y_ok, at_edge;
    logic [10:0]  tx_w, ty_w, sx_w, sy_w;

    assign tx_w     = {1'b0, TankX};
    assign ty_w     = {1'b0, TankY};
    assign sx_w     = {1'b0, ShellX};
    assign sy_w     = {1'b0, ShellY};
    assign tank_dir = dir_t'(direction);

    key_edge_detect #(
        .KEY(FIRE_KEY)
    ) u_fire_edge (
        .clk     (frame_clk),
        .rst_n   (Reset),
        .keycode (keycode),
        .key_edge(fire_edge)
    );

    always_comb begin
        spawn_x = TankX;
        spawn_y = TankY;
        x_ok    = (tx_w >= XMIN_W) && (tx_w <= XMAX_W);
        y_ok    = (ty_w >= YMIN_W) && (ty_w <= YMAX_W);
        case (tank_dir)
            DIR_LEFT: begin
                spawn_x = TankX - OFFSET;
                x_ok    = (tx_w >= XMIN_W + OFF_W) && (tx_w <= XMAX_W + OFF_W);
            end
            DIR_RIGHT: begin
                spawn_x = TankX + OFFSET;
                x_ok    = (tx_w + OFF_W >= XMIN_W) && (tx_w + OFF_W <= XMAX_W);
            end
            DIR_DOWN: begin
                spawn_y = TankY + OFFSET;
                y_ok    = (ty_w + OFF_W >= YMIN_W) && (ty_w + OFF_W <= YMAX_W);
            end
            DIR_UP: begin
                spawn_y = TankY - OFFSET;
                y_ok    = (ty_w >= YMIN_W + OFF_W) && (ty_w <= YMAX_W + OFF_W);
            end
        endcase
        spawn_ok = x_ok && y_ok;
    end

    // Expire one step early so the shell is never drawn on or past the border.
    always_comb begin
        at_edge = 1'b0;
        case (shell_dir)
            DIR_LEFT:  at_edge = (sx_w <= XMIN_W + SPD_W);
            DIR_RIGHT: at_edge = (sx_w + SPD_W >= XMAX_W);
            DIR_DOWN:  at_edge = (sy_w + SPD_W >= YMAX_W);
            DIR_UP:    at_edge = (sy_w <= YMIN_W + SPD_W);
        endcase
    end

    always_comb begin
        state_next = state;
        x_next     = ShellX;
        y_next     = ShellY;
        dir_next   = shell_dir;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fire_edge && spawn_ok) begin
                    state_next = ST_FLYING;
                    x_next     = spawn_x;
                    y_next     = spawn_y;
                    dir_next   = tank_dir;
                    pulse_next = 1'b1;
                end
            end
            ST_FLYING: begin
                if (hit || at_edge) begin
                    x_next     = 10'd0;
                    y_next     = 10'd0;
                    cnt_next   = COOLDOWN_FRAMES;
                    state_next = (COOLDOWN_FRAMES == 8'd0) ? ST_IDLE : ST_COOLDOWN;
                end else begin
                    case (shell_dir)
                        DIR_LEFT:  x_next = ShellX - SHELL_SPEED;
                        DIR_RIGHT: x_next = ShellX + SHELL_SPEED;
                        DIR_DOWN:  y_next = ShellY + SHELL_SPEED;
                        DIR_UP:    y_next = ShellY - SHELL_SPEED;
                    endcase
                end
            end
            ST_COOLDOWN: begin
                cnt_next = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            ShellX     <= 10'd0;
            ShellY     <= 10'd0;
            shell_dir  <= DIR_LEFT;
            cnt        <= 8'd0;
            fire_pulse <= 1'b0;
        end else begin
            state      <= state_next;
            ShellX     <= x_next;
            ShellY     <= y_next;
            shell_dir  <= dir_next;
            cnt        <= cnt_next;
            fire_pulse <= pulse_next;
        end
    end

    assign shell_active = (state == ST_FLYING);
    assign ShellS       = SHELL_SIZE;

endmodule

// File: tb/tb_shell_ctrl.sv
// tb/tb_shell_ctrl.sv - self-checking bench for shell_ctrl
module tb_shell_ctrl;

    localparam int FIRE = 40;
    localparam int COOL = 30;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] TankX, TankY;
    logic [1:0] direction;
    logic       hit;
    logic [9:0] ShellX, ShellY, ShellS;
    logic       shell_active, fire_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 flying, 2 cooling down.
    int m_mode, m_x, m_y, m_dir, m_left, m_pulse, m_prev;

    shell_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode     (keycode),
        .TankX       (TankX),
        .TankY       (TankY),
        .direction   (direction),
        .hit         (hit),
        .ShellX      (ShellX),
        .ShellY      (ShellY),
        .ShellS      (ShellS),
        .shell_active(shell_active),
        .fire_pulse  (fire_pulse)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic void model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_dir = 0; m_left = 0; m_pulse = 0; m_prev = 0;
    endfunction

    function automatic void model_step(int key, int tx, int ty, int dir, int h);
        int sx, sy, nx, ny;
        bit fire, out;
        fire    = (key == FIRE) && (m_prev != FIRE);
        m_prev  = key;
        m_pulse = 0;
        if (m_mode == 0) begin
            if (fire) begin
                sx = tx; sy = ty;
                if (dir == 0) sx = tx - 6;
                else if (dir == 1) sx = tx + 6;
                else if (dir == 2) sy = ty + 6;
                else sy = ty - 6;
                if (sx >= 1 && sx <= 639 && sy >= 1 && sy <= 479) begin
                    m_mode = 1; m_x = sx; m_y = sy; m_dir = dir; m_pulse = 1;
                end
            end
        end else if (m_mode == 1) begin
            nx = m_x; ny = m_y;
            if (m_dir == 0) nx = m_x - 4;
            else if (m_dir == 1) nx = m_x + 4;
            else if (m_dir == 2) ny = m_y + 4;
            else ny = m_y - 4;
            if (m_dir < 2) out = (h != 0) || nx <= 1 || nx >= 639;
            else out = (h != 0) || ny <= 1 || ny >= 479;
            if (out) begin
                m_x = 0; m_y = 0; m_mode = 2; m_left = COOL;
            end else begin
                m_x = nx; m_y = ny;
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end
    endfunction

    task automatic tick();
        int k, tx, ty, d, h;
        k = keycode; tx = TankX; ty = TankY; d = direction; h = hit;
        @(posedge frame_clk);
        model_step(k, tx, ty, d, h);
        #1;
    endtask

    task automatic do_reset();
        keycode = 8'd0; hit = 1'b0;
        Reset = 1'b0;
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic launch(input int tx, input int ty, input int d);
        TankX = 10'(tx); TankY = 10'(ty); direction = 2'(d);
        keycode = 8'(FIRE);
        tick();
        keycode = 8'd0;
    endtask

    task automatic test_reset();
        keycode = 8'd0; hit = 1'b0; TankX = 10'd480; TankY = 10'd240; direction = 2'd0;
        Reset = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if (ShellX !== 10'd0 || ShellY !== 10'd0 || shell_active !== 1'b0 || fire_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d act=%b pulse=%b expected all 0", ShellX, ShellY, shell_active, fire_pulse);
        end
        n_checks++;
        if (ShellS !== 10'd2) begin
            n_errors++;
            $display("FAIL reset_size: got %0d expected 2", ShellS);
        end
        @(posedge frame_clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic test_launch();
        do_reset();
        launch(480, 240, 0);
        n_checks++;
        if (ShellX !== 10'd474 || ShellY !== 10'd240 || shell_active !== 1'b1 || fire_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL launch_spawn: got (%0d,%0d) act=%b pulse=%b expected (474,240) 1 1", ShellX, ShellY, shell_active, fire_pulse);
        end
        tick();
        n_checks++;
        if (ShellX !== 10'd470 || ShellY !== 10'd240 || fire_pulse !== 1'b0 || shell_active !== 1'b1) begin
            n_errors++;
            $display("FAIL launch_step: got (%0d,%0d) act=%b pulse=%b expected (470,240) 1 0", ShellX, ShellY, shell_active, fire_pulse);
        end
    endtask

    task automatic test_cooldown();
        bit seen;
        do_reset();
        launch(479, 240, 0);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (ShellX == 10'd5) seen = 1'b1;
            else tick();
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL cool_reach5: got x=%0d expected shell to reach 5 within 200 frames", ShellX);
        end
        tick();
        n_checks++;
        if (shell_active !== 1'b0 || ShellX !== 10'd0) begin
            n_errors++;
            $display("FAIL cool_expire: got act=%b x=%0d expected 0 0", shell_active, ShellX);
        end
        for (int k = 1; k <= 30; k++) begin
            keycode = (k % 2 == 1) ? 8'(FIRE) : 8'd0;
            tick();
            n_checks++;
            if (shell_active !== 1'b0 || fire_pulse !== 1'b0) begin
                n_errors++;
                $display("FAIL cool_ignore_%0d: got act=%b pulse=%b expected 0 0", k, shell_active, fire_pulse);
            end
        end
        keycode = 8'(FIRE);
        tick();
        keycode = 8'd0;
        n_checks++;
        if (shell_active !== 1'b1 || fire_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL cool_relaunch: got act=%b pulse=%b expected 1 1", shell_active, fire_pulse);
        end
    endtask

    task automatic test_hold();
        int pulses;
        do_reset();
        TankX = 10'd320; TankY = 10'd240; direction = 2'd1;
        keycode = 8'(FIRE);
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (fire_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || shell_active !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_single: got pulses=%0d act=%b expected 1 0", pulses, shell_active);
        end
        keycode = 8'd0;
        tick();
        keycode = 8'(FIRE);
        tick();
        keycode = 8'd0;
        n_checks++;
        if (fire_pulse !== 1'b1 || shell_active !== 1'b1 || ShellX !== 10'd326) begin
            n_errors++;
            $display("FAIL hold_repress: got pulse=%b act=%b x=%0d expected 1 1 326", fire_pulse, shell_active, ShellX);
        end
    endtask

    task automatic test_reject();
        int cases [8][4] = '{
            '{3, 240, 0, 0}, '{7, 240, 0, 1}, '{636, 240, 1, 0}, '{633, 240, 1, 1},
            '{100, 5, 3, 0}, '{100, 7, 3, 1}, '{100, 475, 2, 0}, '{100, 473, 2, 1}
        };
        for (int i = 0; i < 8; i++) begin
            do_reset();
            launch(cases[i][0], cases[i][1], cases[i][2]);
            n_checks++;
            if (shell_active !== 1'(cases[i][3]) || fire_pulse !== 1'(cases[i][3]) ||
                ShellX !== 10'(m_x) || ShellY !== 10'(m_y)) begin
                n_errors++;
                $display("FAIL reject_%0d: got act=%b pulse=%b (%0d,%0d) expected %0d %0d (%0d,%0d)",
                         i, shell_active, fire_pulse, ShellX, ShellY, cases[i][3], cases[i][3], m_x, m_y);
            end
        end
    endtask

    task automatic test_hit_turn();
        do_reset();
        launch(306, 240, 0);
        n_checks++;
        if (ShellX !== 10'd300) begin
            n_errors++;
            $display("FAIL hit_spawn: got x=%0d expected 300", ShellX);
        end
        hit = 1'b1; direction = 2'd3;
        tick();
        hit = 1'b0;
        n_checks++;
        if (shell_active !== 1'b0 || ShellX !== 10'd0 || ShellY !== 10'd0) begin
            n_errors++;
            $display("FAIL hit_expire: got act=%b (%0d,%0d) expected 0 (0,0)", shell_active, ShellX, ShellY);
        end
        for (int k = 1; k <= 31; k++) begin
            keycode = (k % 2 == 1) ? 8'(FIRE) : 8'd0;
            tick();
            n_checks++;
            if (shell_active !== 1'(k == 31) || fire_pulse !== 1'(k == 31) || ShellY !== 10'(m_y)) begin
                n_errors++;
                $display("FAIL hit_cool_%0d: got act=%b pulse=%b y=%0d expected %0d %0d %0d", k, shell_active, fire_pulse, ShellY, k == 31, k == 31, m_y);
            end
        end
        keycode = 8'd0;
        do_reset();
        launch(306, 240, 0);
        direction = 2'd1; TankX = 10'd100; TankY = 10'd100;
        tick(); tick(); tick();
        n_checks++;
        if (ShellX !== 10'd288 || ShellY !== 10'd240 || shell_active !== 1'b1) begin
            n_errors++;
            $display("FAIL turn_ignored: got (%0d,%0d) act=%b expected (288,240) 1", ShellX, ShellY, shell_active);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        launch(320, 240, 2);
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (ShellX !== 10'd0 || ShellY !== 10'd0 || shell_active !== 1'b0 || fire_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL midflight_reset: got (%0d,%0d) act=%b pulse=%b expected all 0", ShellX, ShellY, shell_active, fire_pulse);
        end
        @(posedge frame_clk);
        #1;
        Reset = 1'b1;
        launch(320, 240, 2);
        n_checks++;
        if (shell_active !== 1'b1 || fire_pulse !== 1'b1 || ShellX !== 10'd320 || ShellY !== 10'd246) begin
            n_errors++;
            $display("FAIL after_reset_launch: got act=%b pulse=%b (%0d,%0d) expected 1 1 (320,246)", shell_active, fire_pulse, ShellX, ShellY);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 3);
            keycode   = (r == 0) ? 8'd0 : (r == 3) ? 8'd17 : 8'(FIRE);
            TankX     = 10'($urandom_range(0, 660));
            TankY     = 10'($urandom_range(0, 500));
            direction = 2'($urandom_range(0, 3));
            hit       = ($urandom_range(0, 31) == 0);
            tick();
            n_checks++;
            if (ShellX !== 10'(m_x) || ShellY !== 10'(m_y) ||
                shell_active !== 1'(m_mode == 1) || fire_pulse !== 1'(m_pulse)) begin
                n_errors++;
                $display("FAIL random_%0d: got (%0d,%0d) act=%b pulse=%b expected (%0d,%0d) %0d %0d",
                         i, ShellX, ShellY, shell_active, fire_pulse, m_x, m_y, m_mode == 1, m_pulse);
            end
        end
        hit = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_launch();
        test_cooldown();
        test_hold();
        test_reject();
        test_hit_turn();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
